// File: rtl/camellia_input_loader.sv
// camellia_input_loader
//   Feeds the Camellia-128 encryption top. Packs a 32-bit valid/ready word
//   stream into 128-bit key (KL) and message (M) blocks. A message block is
//   announced with a one-cycle data_valid strobe. Blocks issued to the
//   pipeline are counted until the pipeline retires them with out_rdy, so a
//   new key is only taken once the pipeline has drained.
//
//   Optional build macro LDR_BYTE_SWAP_EN: each word is byte-reversed before
//   it is stored. Without it, words are stored unchanged.
//
// Ports
//   CLK           rising-edge clock
//   RST           asynchronous active-low reset
//   in_valid      word-stream valid
//   in_ready      word-stream ready (first-word gate is combinational)
//   in_data       32-bit word; the first word of a group lands in [127:96]
//   in_is_key     group type, sampled on the first word only (1 = key)
//   out_rdy       one-cycle retire pulse from the encryption pipeline
//   M             last assembled message block
//   KL            last assembled key block
//   data_valid    one-cycle strobe, M valid in that cycle
//   key_valid     a key group has completed since reset
//   inflight      issued blocks not yet retired
//   err_underflow sticky: out_rdy seen with nothing in flight
module camellia_input_loader #(
  parameter  int unsigned MAX_INFLIGHT = 32,
  localparam int unsigned CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_is_key,
  input  logic             out_rdy,
  output logic [127:0]     M,
  output logic [127:0]     KL,
  output logic             data_valid,
  output logic             key_valid,
  output logic [CNT_W-1:0] inflight,
  output logic             err_underflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    EMIT = 2'd2
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [1:0]    word_cnt_q;
  logic [95:0]   shift_q;
  logic          grp_is_key_q;

  logic          gate_ok_c;
  logic          accept_c;
  logic          last_c;
  logic [31:0]   word_in_c;
  logic [127:0]  assembled_c;

  // Word ordering into the block
`ifdef LDR_BYTE_SWAP_EN
  assign word_in_c = {in_data[7:0], in_data[15:8], in_data[23:16], in_data[31:24]};
`else
  assign word_in_c = in_data;
`endif

  assign assembled_c = {shift_q, word_in_c};

  // First-word gate: keys wait for an empty pipeline, messages need a key
  // and room in the pipeline
  assign gate_ok_c = in_is_key ? (inflight == '0)
                               : (key_valid && (inflight != CNT_W'(MAX_INFLIGHT)));

  assign accept_c = in_valid && in_ready;
  assign last_c   = accept_c && (state_q == FILL) && (word_cnt_q == 2'd3);

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and ready; ready is held low while in reset
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = RST && gate_ok_c;
        if (in_valid && in_ready) begin
          state_d = FILL;
        end
      end
      FILL: begin
        in_ready = 1'b1;
        if (in_valid && (word_cnt_q == 2'd3)) begin
          state_d = EMIT;
        end
      end
      EMIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Word assembly and block outputs; blocks are published on entry to EMIT
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      word_cnt_q   <= '0;
      shift_q      <= '0;
      grp_is_key_q <= 1'b0;
      M            <= '0;
      KL           <= '0;
      data_valid   <= 1'b0;
      key_valid    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (accept_c) begin
        shift_q <= assembled_c[95:0];
        if (state_q == IDLE) begin
          grp_is_key_q <= in_is_key;
          word_cnt_q   <= 2'd1;
        end else begin
          word_cnt_q <= word_cnt_q + 2'd1;
        end
      end
      if (last_c) begin
        word_cnt_q <= '0;
        if (grp_is_key_q) begin
          KL        <= assembled_c;
          key_valid <= 1'b1;
        end else begin
          M          <= assembled_c;
          data_valid <= 1'b1;
        end
      end
    end
  end

  // In-flight tracking; issue and retire in one cycle cancel out
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      inflight      <= '0;
      err_underflow <= 1'b0;
    end else begin
      if (data_valid && !out_rdy) begin
        inflight <= inflight + CNT_W'(1);
      end else if (!data_valid && out_rdy) begin
        if (inflight == '0) begin
          err_underflow <= 1'b1;
        end else begin
          inflight <= inflight - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_camellia_input_loader.sv
// Randomized bench for camellia_input_loader against a queue-based block model.
module tb_camellia_input_loader;

  localparam int unsigned MAXI = 6;
  localparam int unsigned CW   = $clog2(MAXI + 1);
  localparam logic [127:0] PAT = 128'h0123456789ABCDEFFEDCBA9876543210;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_data = '0;
  logic          in_is_key = 1'b0;
  logic          out_rdy = 1'b0;
  logic [127:0]  M;
  logic [127:0]  KL;
  logic          data_valid;
  logic          key_valid;
  logic [CW-1:0] inflight;
  logic          err_underflow;

  always #5 CLK = ~CLK;

  camellia_input_loader #(.MAX_INFLIGHT(MAXI)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_is_key    (in_is_key),
    .out_rdy      (out_rdy),
    .M            (M),
    .KL           (KL),
    .data_valid   (data_valid),
    .key_valid    (key_valid),
    .inflight     (inflight),
    .err_underflow(err_underflow)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference model: pending words of the current group, block outputs, counters
  logic [31:0]  mq[$];
  bit           m_key_grp;
  bit           m_emit;
  logic [127:0] m_M;
  logic [127:0] m_KL;
  bit           m_dv;
  bit           m_kv;
  bit           m_err;
  int           m_inf;

  function automatic void model_reset();
    mq.delete();
    m_key_grp = 0; m_emit = 0; m_M = '0; m_KL = '0;
    m_dv = 0; m_kv = 0; m_err = 0; m_inf = 0;
  endfunction

  function automatic logic [31:0] store_word(input logic [31:0] x);
`ifdef LDR_BYTE_SWAP_EN
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
`else
    return x;
`endif
  endfunction

  function automatic bit model_ready(input bit k);
    if (m_emit) return 1'b0;
    if (mq.size() != 0) return 1'b1;
    if (k) return (m_inf == 0);
    return m_kv && (m_inf != int'(MAXI));
  endfunction

  task automatic check_outputs(input string pfx);
    check({pfx, "M"},          M,                    m_M);
    check({pfx, "KL"},         KL,                   m_KL);
    check({pfx, "data_valid"}, 128'(data_valid),     128'(m_dv));
    check({pfx, "key_valid"},  128'(key_valid),      128'(m_kv));
    check({pfx, "inflight"},   128'(inflight),       128'(m_inf));
    check({pfx, "err"},        128'(err_underflow),  128'(m_err));
  endtask

  // One clock cycle: drive at negedge, check ready, advance model, check outputs
  task automatic step(input bit v, input logic [31:0] d, input bit k, input bit o, output bit acc);
    bit r;
    bit nxt_dv;
    bit nxt_emit;
    logic [127:0] blk;
    in_valid = v; in_data = d; in_is_key = k; out_rdy = o;
    #1;
    r = model_ready(k);
    check("in_ready", 128'(in_ready), 128'(r));
    acc = v && r;
    nxt_dv = 0; nxt_emit = 0;
    if (m_dv && !o) m_inf++;
    else if (!m_dv && o) begin
      if (m_inf == 0) m_err = 1;
      else m_inf--;
    end
    if (acc) begin
      if (mq.size() == 0) m_key_grp = k;
      mq.push_back(store_word(d));
      if (mq.size() == 4) begin
        blk = {mq[0], mq[1], mq[2], mq[3]};
        if (m_key_grp) begin m_KL = blk; m_kv = 1; end
        else begin m_M = blk; nxt_dv = 1; end
        mq.delete();
        nxt_emit = 1;
      end
    end
    m_dv = nxt_dv; m_emit = nxt_emit;
    @(posedge CLK); #1;
    check_outputs("");
    @(negedge CLK);
  endtask

  // Send one 4-word group, holding each word until it is taken
  task automatic send_group(input bit k, input logic [127:0] blk, input int orate, input bit gaps);
    bit acc;
    bit v;
    bit o;
    bit kk;
    int budget;
    logic [31:0] w;
    for (int i = 0; i < 4; i++) begin
      w = blk[127 - 32*i -: 32];
      budget = 0;
      acc = 0;
      while (!acc && budget < 300) begin
        v  = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
        o  = ($urandom_range(0, 99) < orate);
        kk = (i == 0) ? k : 1'($urandom_range(0, 1));
        step(v, w, kk, o, acc);
        budget++;
      end
      if (!acc) begin
        check("accept_timeout", 128'(acc), 128'(1));
        return;
      end
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b1; in_is_key = 1'b1; out_rdy = 1'b0;
    RST = 1'b0;
    #1;
    model_reset();
    check("rst_in_ready", 128'(in_ready), 128'(0));
    check_outputs("rst_");
    @(negedge CLK);
    RST = 1'b1;
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit acc;
    int got;
    int bud;
    logic [31:0] w;

    model_reset();
    @(negedge CLK);
    do_reset();

    // Retire with nothing in flight: sticky error, count stays 0
    step(0, '0, 0, 1, acc);
    step(0, '0, 0, 0, acc);

    // Message before any key is held off
    for (int i = 0; i < 3; i++) step(1, 32'h01234567, 0, 0, acc);

    // Key load, then a message block
    send_group(1, PAT, 0, 0);
    step(0, '0, 0, 0, acc);
    send_group(0, PAT, 0, 0);
    step(0, '0, 0, 0, acc);
    step(0, '0, 0, 1, acc);

    // Six back-to-back message blocks with no retires
    for (int g = 0; g < 6; g++) send_group(0, {$urandom, $urandom, $urandom, $urandom}, 0, 0);
    step(0, '0, 0, 0, acc);
    // Pipeline full: a seventh message stalls
    for (int i = 0; i < 3; i++) step(1, 32'hCAFEF00D, 0, 0, acc);
    // Key reload stalls while blocks are in flight, then drains
    for (int i = 0; i < 3; i++) step(1, 32'h11111111, 1, 0, acc);
    for (int i = 0; i < 6; i++) step(1, 32'h11111111, 1, 1, acc);
    send_group(1, {32'h11111111, $urandom, $urandom, $urandom}, 0, 0);
    step(0, '0, 0, 0, acc);

    // Issue and retire in the same cycle at inflight=1
    send_group(0, {$urandom, $urandom, $urandom, $urandom}, 0, 0);
    step(0, '0, 0, 0, acc);
    send_group(0, {$urandom, $urandom, $urandom, $urandom}, 0, 0);
    step(0, '0, 0, 1, acc);

    // Random mix of key and message groups with random retires and gaps
    for (int g = 0; g < 25; g++) begin
      send_group(($urandom_range(0, 4) == 0), {$urandom, $urandom, $urandom, $urandom}, 35, 1);
    end
    for (int i = 0; i < 4; i++) step(0, '0, 0, 1'($urandom_range(0, 1)), acc);

    // Reset in the middle of a message group
    got = 0; bud = 0; w = $urandom;
    while (got < 2 && bud < 100) begin
      step(1, w, 0, 1'($urandom_range(0, 1)), acc);
      if (acc) begin got++; w = $urandom; end
      bud++;
    end
    if (got < 2) check("partial_timeout", 128'(got), 128'(2));
    do_reset();
    send_group(1, {$urandom, $urandom, $urandom, $urandom}, 0, 0);
    step(0, '0, 0, 0, acc);
    send_group(0, {$urandom, $urandom, $urandom, $urandom}, 0, 0);
    step(0, '0, 0, 0, acc);
    step(0, '0, 0, 0, acc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/camellia_input_loader.md
Name: camellia_input_loader

Overview:
- Upstream feeder for the Camellia-128 encryption top.
- Assembles 128-bit key and message blocks from a 32-bit valid/ready word stream.
- Presents KL and M with a one-cycle data_valid strobe.
- Tracks in-flight blocks using the pipeline's out_rdy, so a key is never reloaded while encryptions using the old key are still in the pipeline.

Parameters:
- MAX_INFLIGHT, 32: maximum number of issued blocks not yet retired by out_rdy. The count register is clog2(MAX_INFLIGHT+1) bits.

Ports:
- CLK  input  1  clock; all logic is rising-edge.
- RST  input  1  asynchronous, active-low reset.
- in_valid  input  1  word-stream valid.
- in_ready  output  1  word-stream ready.
- in_data  input  32  word payload; the first word of a group is bits [127:96].
- in_is_key  input  1  sampled on the first word of a group only; 1 = key group, 0 = message group.
- out_rdy  input  1  one-cycle retire pulse from the encryption pipeline.
- M  output  128  assembled message, held until the next message group completes.
- KL  output  128  assembled key, held until the next key group completes.
- data_valid  output  1  one-cycle strobe; M is valid in that cycle.
- key_valid  output  1  set once a key group has completed.
- inflight  output  clog2(MAX_INFLIGHT+1)  number of outstanding blocks.
- err_underflow  output  1  sticky error flag.

Behaviour:
- Reset (RST=0, asynchronous): the following are all 0:
  - M, KL, shift register, word_cnt
  - data_valid, key_valid, inflight, err_underflow, in_ready
  - FSM goes to IDLE.
- A partially received group is discarded on reset.
- Word transfer: a word is accepted when in_valid && in_ready. in_data must be held while in_ready=0.
- FSM states:
  - IDLE: word_cnt=0, waiting for the first word.
    - in_ready=1 only if the first-word gate passes (see below).
    - On accept: latch grp_is_key=in_is_key, store the word, word_cnt=1, go to FILL.
  - FILL: in_ready=1.
    - Each accept shifts the word in and increments word_cnt; in_is_key is ignored.
    - On accepting the 4th word, go to EMIT.
  - EMIT: in_ready=0, lasts exactly one cycle.
    - Key group: KL <= assembled value, key_valid <= 1; data_valid stays 0.
    - Message group: M <= assembled value; data_valid=1 in that same cycle (registered outputs updated on entry).
    - Next state is IDLE.
- First-word gate (IDLE only): in_ready=0 when either condition holds:
  - in_is_key=1 and inflight!=0 (key reload waits for the pipeline to drain);
  - in_is_key=0 and (key_valid=0 or inflight==MAX_INFLIGHT).
- Latency and throughput:
  - 4th word accepted at cycle t; data_valid or KL update visible at t+1.
  - Peak rate is 5 cycles per block.
- inflight counter:
  - +1 on data_valid, −1 on out_rdy.
  - Both in the same cycle: unchanged.
  - out_rdy with inflight==0: count stays 0 and err_underflow is set. It is cleared only by reset.
- Full condition: never exceeds MAX_INFLIGHT, guaranteed by the first-word gate.
- M and KL change only in EMIT, never mid-group.

Optional Feature:
- Macro LDR_BYTE_SWAP_EN.
- Defined: each 32-bit word is byte-reversed before storage; in_data[7:0] lands in bits [31:24] of its word slot.
- Undefined: words are stored as-is.
- Timing, gating and all other behaviour are identical in both cases.

Test Plan:
1. Reset, then a key group of 0x01234567, 0x89ABCDEF, 0xFEDCBA98, 0x76543210 with in_is_key=1 → KL=0x0123456789ABCDEFFEDCBA9876543210 one cycle after the 4th accept; key_valid=1; data_valid never asserts.
2. Message group sent before any key → in_ready stays 0. After the key loads, message words 0x01234567, 0x89ABCDEF, 0xFEDCBA98, 0x76543210 → single-cycle data_valid with M equal to that value; inflight=1.
3. Six back-to-back message groups with out_rdy held 0 → six data_valid pulses, 5 cycles apart; inflight=6. A key group is then stalled until six out_rdy pulses drain inflight to 0, and is accepted on the next cycle.
4. MAX_INFLIGHT=2, three message groups, no out_rdy → third group's first word stalls with in_ready=0. One out_rdy → word accepted next cycle.
5. out_rdy pulse with inflight=0 → err_underflow=1 and stays set; inflight stays 0. Simultaneous data_valid and out_rdy at inflight=1 → inflight stays 1.
6. Assert RST after 2 of 4 message words → all outputs 0 immediately. After release, a fresh 4-word group produces M from the new words only.
